mem_access_stage: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register in the forwarding pipeline. It takes the registered EX/MEM fields and drives the synchronous-read data memory. It performs loads with lane extraction, and word stores. Byte stores (sb) are done as a read-modify-write. Its outputs are the registered MEM/WB fields, plus a stall that freezes the upstream stages.

---
 rtl/mem_access_stage_pkg.sv | 28 ++
 rtl/mem_access_stage_lane_unit.sv | 41 ++++
 rtl/mem_access_stage.sv | 140 ++++++++++++++
 tb/tb_mem_access_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: write-back source select, load type and FSM states.
package mem_access_stage_pkg;

  localparam logic [1:0] WD_SEL_ALU  = 2'b00;
  localparam logic [1:0] WD_SEL_MEM  = 2'b01;
  localparam logic [1:0] WD_SEL_PC   = 2'b10;
  localparam logic [1:0] WD_SEL_ZERO = 2'b11;

  localparam logic [1:0] LD_W   = 2'b00;
  localparam logic [1:0] LD_LB  = 2'b01;
  localparam logic [1:0] LD_LBU = 2'b10;
  localparam logic [1:0] LD_LH  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LD_WAIT  = 2'b01,
    SB_MERGE = 2'b10
  } mem_state_e;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_access_stage_lane_unit.sv
// Combinational lane logic: load extraction from the read word and the sb byte merge.
module mem_lane_unit
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  byte_off_i,
  input  logic [1:0]  mem_data_sel_i,
  input  logic [7:0]  sb_data_i,
  output logic [31:0] load_val_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Load lane extraction; bit 0 of the offset is ignored for halfwords.
  always_comb begin
    byte_s = rdata_i[{byte_off_i, 3'b000} +: 8];
    half_s = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (mem_data_sel_i)
      LD_W:    load_val_o = rdata_i;
      LD_LB:   load_val_o = sext8(byte_s);
      LD_LBU:  load_val_o = {24'd0, byte_s};
      LD_LH:   load_val_o = sext16(half_s);
      default: load_val_o = rdata_i;
    endcase
  end

  // Byte-store merge: replace one little-endian lane of the read word.
  always_comb begin
    merged_o = rdata_i;
    case (byte_off_i)
      2'd0:    merged_o[7:0]   = sb_data_i;
      2'd1:    merged_o[15:8]  = sb_data_i;
      2'd2:    merged_o[23:16] = sb_data_i;
      2'd3:    merged_o[31:24] = sb_data_i;
      default: merged_o        = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the synchronous data memory, handles loads and sb read-modify-write,
// and registers the MEM/WB fields.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DMEM_AW = 14
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        alu_result_i,
  input  logic [31:0]        mem_wd_i,
  input  logic               mem_we_i,
  input  logic [1:0]         mem_data_sel_i,
  input  logic [4:0]         wr_i,
  input  logic [1:0]         wd_sel_i,
  input  logic               regfile_we_i,
  input  logic [31:0]        return_pc_i,
  input  logic [31:0]        current_pc_i,
  input  logic               is_sb_i,
  input  logic [31:0]        dmem_rdata_i,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic               dmem_we_o,
  output logic [31:0]        dmem_wdata_o,
  output logic               stall_o,
  output logic [31:0]        wb_wd_o,
  output logic [4:0]         wr_o,
  output logic               regfile_we_o,
  output logic [31:0]        current_pc_o
);

  mem_state_e  state_q, state_d;
  logic [31:0] wb_wd_q, wb_wd_d;
  logic [4:0]  wr_q, wr_d;
  logic        rf_we_q, rf_we_d;
  logic [31:0] pc_q, pc_d;

  logic        is_load_s, is_sb_s, is_sw_s;
  logic        dmem_we_s, stall_s;
  logic [31:0] dmem_wdata_s, wd_mux_s, load_val_s, merged_s;

  // A load wins over a simultaneous store request.
  assign is_load_s = (wd_sel_i == WD_SEL_MEM);
  assign is_sb_s   = mem_we_i & is_sb_i & ~is_load_s;
  assign is_sw_s   = mem_we_i & ~is_sb_i & ~is_load_s;

  mem_lane_unit u_lane (
    .rdata_i        (dmem_rdata_i),
    .byte_off_i     (alu_result_i[1:0]),
    .mem_data_sel_i (mem_data_sel_i),
    .sb_data_i      (mem_wd_i[7:0]),
    .load_val_o     (load_val_s),
    .merged_o       (merged_s)
  );

  // Non-load write-back source select.
  always_comb begin
    case (wd_sel_i)
      WD_SEL_ALU:  wd_mux_s = alu_result_i;
      WD_SEL_PC:   wd_mux_s = return_pc_i;
      WD_SEL_ZERO: wd_mux_s = 32'd0;
      default:     wd_mux_s = 32'd0;
    endcase
  end

  // Next-state, memory strobes and MEM/WB next values.
  always_comb begin
    state_d      = state_q;
    wb_wd_d      = wb_wd_q;
    wr_d         = wr_q;
    rf_we_d      = rf_we_q;
    pc_d         = pc_q;
    dmem_we_s    = 1'b0;
    stall_s      = 1'b0;
    dmem_wdata_s = mem_wd_i;
    case (state_q)
      IDLE: begin
        if (is_load_s || is_sb_s) begin
          stall_s = 1'b1;
          wb_wd_d = 32'd0;
          wr_d    = 5'd0;
          rf_we_d = 1'b0;
          pc_d    = 32'd0;
          state_d = is_load_s ? LD_WAIT : SB_MERGE;
        end else begin
          dmem_we_s = is_sw_s;
          wb_wd_d   = wd_mux_s;
          wr_d      = wr_i;
          rf_we_d   = regfile_we_i;
          pc_d      = current_pc_i;
          state_d   = IDLE;
        end
      end
      LD_WAIT: begin
        wb_wd_d = load_val_s;
        wr_d    = wr_i;
        rf_we_d = regfile_we_i;
        pc_d    = current_pc_i;
        state_d = IDLE;
      end
      SB_MERGE: begin
        dmem_we_s    = 1'b1;
        dmem_wdata_s = merged_s;
        wb_wd_d      = wd_mux_s;
        wr_d         = wr_i;
        rf_we_d      = regfile_we_i;
        pc_d         = current_pc_i;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and MEM/WB register bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wb_wd_q <= 32'd0;
      wr_q    <= 5'd0;
      rf_we_q <= 1'b0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      wb_wd_q <= wb_wd_d;
      wr_q    <= wr_d;
      rf_we_q <= rf_we_d;
      pc_q    <= pc_d;
    end
  end

  // Reset also cancels any pending sb merge write.
  assign dmem_addr_o  = alu_result_i[DMEM_AW+1:2];
  assign dmem_we_o    = dmem_we_s & ~rst_i;
  assign stall_o      = stall_s & ~rst_i;
  assign dmem_wdata_o = dmem_wdata_s;
  assign wb_wd_o      = wb_wd_q;
  assign wr_o         = wr_q;
  assign regfile_we_o = rf_we_q;
  assign current_pc_o = pc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench: directed scenarios plus randomized instruction stream against a word-level memory model.
module tb_mem_access_stage;

  localparam int AW    = 14;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [31:0]   alu_result_i, mem_wd_i, return_pc_i, current_pc_i, dmem_rdata_i;
  logic          mem_we_i, regfile_we_i, is_sb_i;
  logic [1:0]    mem_data_sel_i, wd_sel_i;
  logic [4:0]    wr_i;
  logic [AW-1:0] dmem_addr_o;
  logic          dmem_we_o, stall_o, regfile_we_o;
  logic [31:0]   dmem_wdata_o, wb_wd_o, current_pc_o;
  logic [4:0]    wr_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ram     [WORDS];
  logic [31:0] ref_mem [WORDS];

  always #5 clk = ~clk;

  mem_access_stage #(.DMEM_AW(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .alu_result_i(alu_result_i), .mem_wd_i(mem_wd_i),
    .mem_we_i(mem_we_i), .mem_data_sel_i(mem_data_sel_i), .wr_i(wr_i), .wd_sel_i(wd_sel_i),
    .regfile_we_i(regfile_we_i), .return_pc_i(return_pc_i), .current_pc_i(current_pc_i),
    .is_sb_i(is_sb_i), .dmem_rdata_i(dmem_rdata_i), .dmem_addr_o(dmem_addr_o),
    .dmem_we_o(dmem_we_o), .dmem_wdata_o(dmem_wdata_o), .stall_o(stall_o),
    .wb_wd_o(wb_wd_o), .wr_o(wr_o), .regfile_we_o(regfile_we_o), .current_pc_o(current_pc_o)
  );

  // Synchronous-read RAM, read-before-write.
  always @(posedge clk) begin
    if (dmem_we_o) ram[dmem_addr_o] <= dmem_wdata_o;
    dmem_rdata_i <= ram[dmem_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input logic [1:0] sel);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'd255;
    h = (w >> (16 * (off / 2))) & 32'd65535;
    case (sel)
      2'd0:    return w;
      2'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
      2'd2:    return b;
      default: return (h >= 32'd32768) ? h - 32'd65536 : h;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input int off, input logic [31:0] d);
    return (w & ~(32'hFF << (8 * off))) | ((d & 32'hFF) << (8 * off));
  endfunction

  // Issue one instruction (inputs driven #1 after an edge) and check it through completion.
  task automatic run_instr(input logic [1:0] wd_sel, input logic [1:0] sel, input logic we,
                           input logic sb, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] wr, input logic rfwe, input logic [31:0] rpc,
                           input logic [31:0] pc);
    bit          is_load, is_sb, is_sw;
    int          widx, off;
    logic [31:0] exp_wd;
    wd_sel_i = wd_sel; mem_data_sel_i = sel; mem_we_i = we; is_sb_i = sb;
    alu_result_i = alu; mem_wd_i = wd; wr_i = wr; regfile_we_i = rfwe;
    return_pc_i = rpc; current_pc_i = pc;
    is_load = (wd_sel == 2'b01);
    is_sb   = we && sb && !is_load;
    is_sw   = we && !sb && !is_load;
    widx    = int'(alu[AW+1:2]);
    off     = int'(alu[1:0]);
    case (wd_sel)
      2'b00:   exp_wd = alu;
      2'b01:   exp_wd = ref_load(ref_mem[widx], off, sel);
      2'b10:   exp_wd = rpc;
      default: exp_wd = 32'd0;
    endcase
    #1;
    chk("addr", 32'(dmem_addr_o), 32'(widx));
    if (is_load || is_sb) begin
      chk("stall_c1", 32'(stall_o), 32'd1);
      chk("we_c1", 32'(dmem_we_o), 32'd0);
      @(posedge clk); #1;
      chk("bubble_rfwe", 32'(regfile_we_o), 32'd0);
      chk("stall_c2", 32'(stall_o), 32'd0);
      chk("addr_c2", 32'(dmem_addr_o), 32'(widx));
      if (is_sb) begin
        chk("sb_we", 32'(dmem_we_o), 32'd1);
        chk("sb_wdata", dmem_wdata_o, ref_merge(ref_mem[widx], off, wd));
        ref_mem[widx] = ref_merge(ref_mem[widx], off, wd);
      end else begin
        chk("ld_we_c2", 32'(dmem_we_o), 32'd0);
      end
    end else begin
      chk("stall", 32'(stall_o), 32'd0);
      chk("we", 32'(dmem_we_o), is_sw ? 32'd1 : 32'd0);
      if (is_sw) begin
        chk("sw_wdata", dmem_wdata_o, wd);
        ref_mem[widx] = wd;
      end
    end
    @(posedge clk); #1;
    chk("wb_wd", wb_wd_o, exp_wd);
    chk("wr", 32'(wr_o), 32'(wr));
    chk("rfwe", 32'(regfile_we_o), 32'(rfwe));
    chk("pc", current_pc_o, pc);
  endtask

  initial begin
    int mism;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    rst_i = 1'b1; alu_result_i = 32'd0; mem_wd_i = 32'd0; mem_we_i = 1'b0; mem_data_sel_i = 2'd0;
    wr_i = 5'd0; wd_sel_i = 2'd0; regfile_we_i = 1'b0; return_pc_i = 32'd0; current_pc_i = 32'd0;
    is_sb_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_wb_wd", wb_wd_o, 32'd0);
    chk("rst_wr", 32'(wr_o), 32'd0);
    chk("rst_rfwe", 32'(regfile_we_o), 32'd0);
    chk("rst_pc", current_pc_o, 32'd0);
    rst_i = 1'b0;

    // ALU op
    run_instr(2'b00, 2'd0, 1'b0, 1'b0, 32'h12345678, 32'd0, 5'd5, 1'b1, 32'd0, 32'h100);
    // lb / lbu at 0x103 of word 0x80FF0011
    ram[32'h40] = 32'h80FF0011; ref_mem[32'h40] = 32'h80FF0011;
    run_instr(2'b01, 2'd1, 1'b0, 1'b0, 32'h103, 32'd0, 5'd7, 1'b1, 32'd0, 32'h104);
    chk("lb_value", wb_wd_o, 32'hFFFFFF80);
    run_instr(2'b01, 2'd2, 1'b0, 1'b0, 32'h103, 32'd0, 5'd8, 1'b1, 32'd0, 32'h108);
    chk("lbu_value", wb_wd_o, 32'h00000080);
    // sb at 0x101 into 0x11223344
    ram[32'h40] = 32'h11223344; ref_mem[32'h40] = 32'h11223344;
    run_instr(2'b00, 2'd0, 1'b1, 1'b1, 32'h101, 32'hAB, 5'd0, 1'b0, 32'd0, 32'h10C);
    chk("sb_mem", ram[32'h40], 32'h1122AB44);
    // sw then lw, same address
    run_instr(2'b00, 2'd0, 1'b1, 1'b0, 32'h200, 32'hDEADBEEF, 5'd0, 1'b0, 32'd0, 32'h110);
    run_instr(2'b01, 2'd0, 1'b0, 1'b0, 32'h200, 32'd0, 5'd9, 1'b1, 32'd0, 32'h114);
    chk("sw_lw_value", wb_wd_o, 32'hDEADBEEF);
    // load with mem_we set: no write
    run_instr(2'b01, 2'd3, 1'b1, 1'b0, 32'h202, 32'h55555555, 5'd10, 1'b1, 32'd0, 32'h118);
    chk("ld_prio_value", wb_wd_o, 32'hFFFFDEAD);

    // Reset for 2 cycles in the middle of an sb: the merge write must not happen.
    wd_sel_i = 2'b00; mem_we_i = 1'b1; is_sb_i = 1'b1; alu_result_i = 32'h300; mem_wd_i = 32'h77;
    regfile_we_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1; #1;
    chk("rst_sb_we", 32'(dmem_we_o), 32'd0);
    chk("rst_sb_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    chk("rst2_we", 32'(dmem_we_o), 32'd0);
    chk("rst2_stall", 32'(stall_o), 32'd0);
    chk("rst2_rfwe", 32'(regfile_we_o), 32'd0);
    chk("rst2_wb_wd", wb_wd_o, 32'd0);
    mem_we_i = 1'b0; is_sb_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    run_instr(2'b10, 2'd0, 1'b0, 1'b1, 32'h0, 32'd0, 5'd3, 1'b1, 32'hCAFE0004, 32'h11C);

    // Randomized instruction stream
    for (int k = 0; k < 300; k++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 4);
      a    = {16'd0, 14'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      case (kind)
        0: run_instr((($urandom_range(0, 2)) == 0) ? 2'b00 : ((($urandom_range(0, 1)) == 0) ? 2'b10 : 2'b11),
                     2'($urandom), 1'b0, 1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
                     $urandom, $urandom);
        1: run_instr(2'b01, 2'($urandom), 1'b0, 1'($urandom), a, $urandom, 5'($urandom), 1'b1,
                     $urandom, $urandom);
        2: run_instr(2'b00, 2'($urandom), 1'b1, 1'b0, a, $urandom, 5'($urandom), 1'b0,
                     $urandom, $urandom);
        3: run_instr(2'b00, 2'($urandom), 1'b1, 1'b1, a, $urandom, 5'($urandom), 1'b0,
                     $urandom, $urandom);
        default: run_instr(2'b01, 2'($urandom), 1'b1, 1'($urandom), a, $urandom, 5'($urandom), 1'b1,
                           $urandom, $urandom);
      endcase
    end

    mism = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
